// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants, segment decode table, anode codes and
//                converter state encoding for the 4-digit 7-segment scan
//                driver. Segment vectors are ordered [0:6] = a..g and are
//                active-low. Anode codes are active-low, bit3 = thousands.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b1111110;

    localparam logic [3:0] AN_THOU  = 4'b0111;
    localparam logic [3:0] AN_HUND  = 4'b1011;
    localparam logic [3:0] AN_TENS  = 4'b1101;
    localparam logic [3:0] AN_UNITS = 4'b1110;

    // Digit index encoding used by the scanner.
    localparam logic [1:0] IDX_THOU  = 2'd0;
    localparam logic [1:0] IDX_HUND  = 2'd1;
    localparam logic [1:0] IDX_TENS  = 2'd2;
    localparam logic [1:0] IDX_UNITS = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    // Active-low segment pattern for one BCD nibble; anything above 9 blanks.
    function automatic seg_t bcd_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] idx_to_anode(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            IDX_THOU: an = AN_THOU;
            IDX_HUND: an = AN_HUND;
            IDX_TENS: an = AN_TENS;
            default:  an = AN_UNITS;
        endcase
        return an;
    endfunction

    // Double-dabble correction applied before each left shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : Value handshake and display pins of the scan driver.
//                master : value producer / board side (drives val, val_vld)
//                slave  : the scan driver (drives val_rdy, seg, placement,
//                         ovf)
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int VAL_W = 14
);
    logic [VAL_W-1:0] val;
    logic             val_vld;
    logic             val_rdy;
    logic [0:6]       seg;
    logic [3:0]       placement;
    logic             ovf;

    modport master (
        output val, val_vld,
        input  val_rdy, seg, placement, ovf
    );

    modport slave (
        input  val, val_vld,
        output val_rdy, seg, placement, ovf
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary to 4-digit BCD converter.
//                Accepts one value per val_vld/val_rdy transfer, spends
//                VAL_W cycles shifting, then one LOAD cycle presenting the
//                result with a single-cycle done pulse.
//  Ports       : clk, rst       clock / synchronous active-high reset
//                val, val_vld   value in, valid
//                val_rdy        idle, can accept a value
//                bcd            4 BCD digits, thousands in [15:12]
//                ovf            accepted value exceeded 9999
//                done           high during LOAD; bcd/ovf valid
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VAL_W = 14
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [VAL_W-1:0] val,
    input  wire logic             val_vld,
    output logic                  val_rdy,
    output logic [15:0]           bcd,
    output logic                  ovf,
    output logic                  done
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    conv_state_t      r_state;
    conv_state_t      w_state_next;
    logic [VAL_W-1:0] r_bin;
    logic [15:0]      r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [11:0]      w_adj_lo;
    logic [2:0]       w_adj_top;
    logic             w_last_shift;

    // Lower three digits get the full correction.
    for (genvar g = 0; g < 3; g++) begin : g_adj
        assign w_adj_lo[g*4 +: 4] = dabble_adj(r_bcd[g*4 +: 4]);
    end

    // Only the low 3 bits of the corrected top digit survive the shift;
    // 3-bit arithmetic wraps to exactly those bits.
    assign w_adj_top    = r_bcd[14:12] + ((r_bcd[15:12] >= 4'd5) ? 3'd3 : 3'd0);
    assign w_last_shift = (r_cnt == CNT_W'(VAL_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (val_vld)      w_state_next = SHIFT;
            SHIFT:   if (w_last_shift) w_state_next = LOAD;
            LOAD:                      w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (val_vld) begin
                        r_bin <= val;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_ovf <= (32'(val) > 32'd9999);
                    end
                end
                SHIFT: begin
                    r_bcd <= {w_adj_top, w_adj_lo, r_bin[VAL_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign val_rdy = (r_state == IDLE);
    assign done    = (r_state == LOAD);
    assign bcd     = r_bcd;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Drives a 4-digit common-anode 7-segment display from a
//                binary value. A sequential converter produces BCD, which is
//                held in a display buffer and time-multiplexed across the
//                digits, SCAN_DIV clocks per digit. seg/placement/ovf are
//                registered straight to pins.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                bus        seg7_scan_driver_if.slave:
//                           val/val_vld/val_rdy handshake,
//                           seg[0:6] (a..g, active-low),
//                           placement[3:0] (active-low, bit3 thousands),
//                           ovf (last accepted value > 9999)
//  Options     : SEG7_LEADING_ZERO_BLANK_EN - blank leading zero digits
//                (units digit always shown).
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 60000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [15:0]        w_conv_bcd;
    logic               w_conv_ovf;
    logic               w_conv_done;
    logic               w_conv_rdy;

    logic [15:0]        r_disp;
    logic               r_ovf;
    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]         r_idx;
    seg_t               r_seg;
    logic [3:0]         r_place;

    logic               w_tc;
    logic [1:0]         w_idx_next;
    logic [15:0]        w_disp_eff;
    logic               w_ovf_eff;
    logic [3:0]         w_nib;
    logic               w_blank;
    seg_t               w_seg_next;

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .val     (bus.val),
        .val_vld (bus.val_vld),
        .val_rdy (w_conv_rdy),
        .bcd     (w_conv_bcd),
        .ovf     (w_conv_ovf),
        .done    (w_conv_done)
    );

    assign w_tc       = (r_dwell == DWELL_W'(SCAN_DIV - 1));
    assign w_idx_next = w_tc ? r_idx + 2'd1 : r_idx;

    // Bypass the buffer during LOAD so the fresh result reaches the pins on
    // the same edge that writes the buffer.
    assign w_disp_eff = w_conv_done ? w_conv_bcd : r_disp;
    assign w_ovf_eff  = w_conv_done ? w_conv_ovf : r_ovf;

    always_comb begin
        w_nib   = w_disp_eff[3:0];
        w_blank = 1'b0;
        case (w_idx_next)
            IDX_THOU: w_nib = w_disp_eff[15:12];
            IDX_HUND: w_nib = w_disp_eff[11:8];
            IDX_TENS: w_nib = w_disp_eff[7:4];
            default:  w_nib = w_disp_eff[3:0];
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every more significant digit
        // are zero; units is never blanked.
        case (w_idx_next)
            IDX_THOU: w_blank = (w_disp_eff[15:12] == 4'd0);
            IDX_HUND: w_blank = (w_disp_eff[15:8]  == 8'd0);
            IDX_TENS: w_blank = (w_disp_eff[15:4]  == 12'd0);
            default:  w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
        if (w_ovf_eff) begin
            w_seg_next = SEG_DASH;
        end else if (w_blank) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = bcd_to_seg(w_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp  <= '0;
            r_ovf   <= 1'b0;
            r_dwell <= '0;
            r_idx   <= IDX_UNITS;
            r_seg   <= bcd_to_seg(4'd0);
            r_place <= AN_UNITS;
        end else begin
            if (w_conv_done) begin
                r_disp <= w_conv_bcd;
                r_ovf  <= w_conv_ovf;
            end
            r_dwell <= w_tc ? '0 : r_dwell + DWELL_W'(1);
            r_idx   <= w_idx_next;
            // seg and placement share one edge so digits never bleed.
            r_seg   <= w_seg_next;
            r_place <= idx_to_anode(w_idx_next);
        end
    end

    assign bus.val_rdy   = w_conv_rdy;
    assign bus.seg       = r_seg;
    assign bus.placement = r_place;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver with SCAN_DIV=4.
//                Stimulus pushes expected digit presentations into a
//                scoreboard; a negedge monitor pops one entry on each
//                placement change and also checks dwell length and rotation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int VAL_W    = 14;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.VAL_W(VAL_W)) bus();

    seg7_scan_driver #(
        .VAL_W    (VAL_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] place;
        logic [6:0] seg;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] seg_tab [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    logic [3:0] place_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Queue the four digit presentations expected after the current units dwell.
    task automatic push_display(input int d3, input int d2, input int d1, input int d0, input bit ovf);
        int   d [4];
        bit   blank [4];
        exp_t e;
        d = '{d3, d2, d1, d0};
        blank = '{1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank[0] = (d3 == 0);
        blank[1] = blank[0] && (d2 == 0);
        blank[2] = blank[1] && (d1 == 0);
`endif
        for (int i = 0; i < 4; i++) begin
            e.place = place_tab[i];
            e.ovf   = ovf;
            if (ovf)           e.seg = 7'b1111110;
            else if (blank[i]) e.seg = 7'b1111111;
            else               e.seg = seg_tab[d[i]];
            sb.push_back(e);
        end
    endtask

    task automatic expect_display(input int d3, input int d2, input int d1, input int d0, input bit ovf);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.placement == 4'b1110) seen = 1'b1;
        end
        check("units_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        push_display(d3, d2, d1, d0, ovf);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 100 && bus.val_rdy !== 1'b1; i++) @(negedge clk);
        check("wait_rdy", {31'd0, bus.val_rdy}, 32'd1);
    endtask

    // Issue one transfer and return how many cycles val_rdy stayed low.
    task automatic do_convert(input logic [VAL_W-1:0] v, output int lowcnt);
        wait_rdy();
        @(negedge clk);
        bus.val     = v;
        bus.val_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.val_vld = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.val_rdy) break;
            lowcnt++;
        end
    endtask

    // Monitor: one scoreboard pop per digit change, plus dwell/rotation checks.
    logic [3:0] mon_prev;
    int         mon_run;
    bit         mon_first = 1'b1;
    bit         mon_dwell_ok = 1'b0;
    exp_t       mon_e;

    function automatic logic [3:0] next_place(input logic [3:0] p);
        case (p)
            4'b0111: return 4'b1011;
            4'b1011: return 4'b1101;
            4'b1101: return 4'b1110;
            default: return 4'b0111;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mon_first    = 1'b1;
            mon_dwell_ok = 1'b0;
        end else if (mon_first) begin
            mon_prev  = bus.placement;
            mon_run   = 1;
            mon_first = 1'b0;
        end else if (bus.placement != mon_prev) begin
            if (mon_dwell_ok) check("dwell_cycles", mon_run, SCAN_DIV);
            check("rotation", {28'd0, bus.placement}, {28'd0, next_place(mon_prev)});
            mon_dwell_ok = 1'b1;
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("digit_place_seg_ovf",
                      {20'd0, bus.placement, bus.seg, bus.ovf},
                      {20'd0, mon_e.place, mon_e.seg, mon_e.ovf});
            end
            mon_prev = bus.placement;
            mon_run  = 1;
        end else begin
            mon_run++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lowcnt;
        bus.val     = '0;
        bus.val_vld = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rdy",   {31'd0, bus.val_rdy},   32'd1);
        check("reset_ovf",   {31'd0, bus.ovf},       32'd0);
        check("reset_place", {28'd0, bus.placement}, 32'b1110);
        check("reset_seg",   {25'd0, bus.seg},       32'b0000001);
        expect_display(0, 0, 0, 0, 1'b0);

        // Basic conversion and handshake latency
        do_convert(14'd1234, lowcnt);
        check("rdy_low_1234", lowcnt, 32'd15);
        expect_display(1, 2, 3, 4, 1'b0);

        // Busy ignore: second request during conversion is dropped
        wait_rdy();
        @(negedge clk);
        bus.val     = 14'd5678;
        bus.val_vld = 1'b1;
        @(posedge clk);
        #1 bus.val_vld = 1'b0;
        lowcnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus.val     = 14'd9999;
                bus.val_vld = 1'b1;
            end else begin
                bus.val_vld = 1'b0;
            end
            if (bus.val_rdy) break;
            lowcnt++;
        end
        bus.val_vld = 1'b0;
        check("rdy_low_5678", lowcnt, 32'd15);
        repeat (3) @(negedge clk);
        check("single_transfer_rdy", {31'd0, bus.val_rdy}, 32'd1);
        expect_display(5, 6, 7, 8, 1'b0);

        // Overflow shows dashes, then clears on next load
        do_convert(14'd12000, lowcnt);
        check("rdy_low_12000", lowcnt, 32'd15);
        check("ovf_set", {31'd0, bus.ovf}, 32'd1);
        expect_display(0, 0, 0, 0, 1'b1);
        do_convert(14'd7, lowcnt);
        check("ovf_clear", {31'd0, bus.ovf}, 32'd0);
        expect_display(0, 0, 0, 7, 1'b0);

        // Maximum in-range value
        do_convert(14'd9999, lowcnt);
        expect_display(9, 9, 9, 9, 1'b0);

        // Reset in the middle of a conversion
        wait_rdy();
        @(negedge clk);
        bus.val     = 14'd4321;
        bus.val_vld = 1'b1;
        @(posedge clk);
        #1 bus.val_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_rdy",   {31'd0, bus.val_rdy},   32'd1);
        check("midrst_ovf",   {31'd0, bus.ovf},       32'd0);
        check("midrst_place", {28'd0, bus.placement}, 32'b1110);
        check("midrst_seg",   {25'd0, bus.seg},       32'b0000001);
        expect_display(0, 0, 0, 0, 1'b0);
        do_convert(14'd16, lowcnt);
        check("rdy_low_16", lowcnt, 32'd15);
        expect_display(0, 0, 1, 6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
